// File: rtl/lif_pkg.sv
// ============================================================================
// Module : lif_pkg
// Brief  : Shared types and constants for the LIF step scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } lif_state_t;

    localparam int c_default_w = 8;
    // Extra carry bits kept on the leak+current sum before saturation.
    localparam int c_sat_extra = 1;

endpackage

`default_nettype wire

// File: rtl/lif_update_core.sv
// ============================================================================
// Module : lif_update_core
// Brief  : Saturating leak-integrate and unsigned threshold compare.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lif_update_core
    import lif_pkg::*;
#(
    parameter int W = c_default_w
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] state,
    input  logic [2:0]   leak_shift,
    input  logic [W-1:0] threshold,
    output logic [W-1:0] next_state,
    output logic         fire
);

    logic [W+c_sat_extra-1:0] w_sum;
    logic [W-1:0]             w_sat;

    assign w_sum      = {{c_sat_extra{1'b0}}, cur} + {{c_sat_extra{1'b0}}, (state >> leak_shift)};
    assign w_sat      = (|w_sum[W+c_sat_extra-1:W]) ? {W{1'b1}} : w_sum[W-1:0];
    assign fire       = (w_sat >= threshold);
    assign next_state = fire ? {W{1'b0}} : w_sat;

endmodule

`default_nettype wire

// File: rtl/lif_step_scheduler.sv
// ============================================================================
// Module : lif_step_scheduler
// Brief  : Sweeps N_NEURONS membrane states through one shared LIF update
//          per timestep and emits spikes as indexed valid/ready events.
//          Optional refractory hold is enabled by `LIF_REFRACTORY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lif_step_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int W            = c_default_w,
    parameter int REFRAC_STEPS = 2,
    localparam int c_iw        = $clog2(N_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_start,
    input  logic [N_NEURONS*W-1:0] currents,
    input  logic [W-1:0]           threshold,
    input  logic [2:0]             leak_shift,
    output logic                   step_busy,
    output logic                   step_done,
    output logic                   spk_valid,
    input  logic                   spk_ready,
    output logic [c_iw-1:0]        spk_idx,
    input  logic [c_iw-1:0]        rd_idx,
    output logic [W-1:0]           rd_state
);

    localparam logic [c_iw-1:0] c_last = c_iw'(N_NEURONS - 1);

    lif_state_t             r_fsm;
    logic [c_iw-1:0]        r_idx;
    logic [W-1:0]           r_state [N_NEURONS];
    logic [N_NEURONS*W-1:0] r_cur_sh;
    logic [W-1:0]           r_thr_sh;
    logic [2:0]             r_leak_sh;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_spk_valid;
    logic [c_iw-1:0]        r_spk_idx;

    logic [W-1:0]           w_next;
    logic                   w_fire;

`ifdef LIF_REFRACTORY_EN
    localparam int c_rw = $clog2(REFRAC_STEPS + 1);
    logic [c_rw-1:0]        r_refrac [N_NEURONS];
`else
    logic                   w_unused_refrac;
    assign w_unused_refrac = ^REFRAC_STEPS;
`endif

    lif_update_core #(.W(W)) u_core (
        .cur        (r_cur_sh[int'(r_idx)*W +: W]),
        .state      (r_state[r_idx]),
        .leak_shift (r_leak_sh),
        .threshold  (r_thr_sh),
        .next_state (w_next),
        .fire       (w_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_idx       <= '0;
            r_cur_sh    <= '0;
            r_thr_sh    <= '0;
            r_leak_sh   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spk_valid <= 1'b0;
            r_spk_idx   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_state[i]  <= '0;
`ifdef LIF_REFRACTORY_EN
                r_refrac[i] <= '0;
`endif
            end
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (step_start) begin
                        r_cur_sh  <= currents;
                        r_thr_sh  <= threshold;
                        r_leak_sh <= leak_shift;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_fsm     <= CALC;
                    end
                end
                CALC: begin
`ifdef LIF_REFRACTORY_EN
                    if (r_refrac[r_idx] != '0) begin
                        r_state[r_idx]  <= '0;
                        r_refrac[r_idx] <= r_refrac[r_idx] - 1'b1;
                        if (r_idx == c_last) begin
                            r_done <= 1'b1;
                            r_fsm  <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else
`endif
                    begin
                        r_state[r_idx] <= w_next;
                        if (w_fire) begin
`ifdef LIF_REFRACTORY_EN
                            r_refrac[r_idx] <= c_rw'(REFRAC_STEPS);
`endif
                            r_spk_idx   <= r_idx;
                            r_spk_valid <= 1'b1;
                            r_fsm       <= EMIT;
                        end else if (r_idx == c_last) begin
                            r_done <= 1'b1;
                            r_fsm  <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (spk_ready) begin
                        r_spk_valid <= 1'b0;
                        if (r_idx == c_last) begin
                            r_done <= 1'b1;
                            r_fsm  <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_fsm <= CALC;
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_fsm  <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign step_busy = r_busy;
    assign step_done = r_done;
    assign spk_valid = r_spk_valid;
    assign spk_idx   = r_spk_idx;
    assign rd_state  = r_state[rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_lif_step_scheduler.sv
// ============================================================================
// Module : tb_lif_step_scheduler
// Brief  : Directed self-checking bench for lif_step_scheduler (N=4, W=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lif_step_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_start = 1'b0;
    logic [31:0] currents = '0;
    logic [7:0]  threshold = '0;
    logic [2:0]  leak_shift = '0;
    logic        step_busy;
    logic        step_done;
    logic        spk_valid;
    logic        spk_ready = 1'b1;
    logic [1:0]  spk_idx;
    logic [1:0]  rd_idx = '0;
    logic [7:0]  rd_state;

    int checks   = 0;
    int failures = 0;
    int ev_q[$];
    int done_cyc;
    int unstable;
    logic busy_c1;

    always #5 clk = ~clk;

    lif_step_scheduler #(.N_NEURONS(4), .W(8), .REFRAC_STEPS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_start (step_start),
        .currents   (currents),
        .threshold  (threshold),
        .leak_shift (leak_shift),
        .step_busy  (step_busy),
        .step_done  (step_done),
        .spk_valid  (spk_valid),
        .spk_ready  (spk_ready),
        .spk_idx    (spk_idx),
        .rd_idx     (rd_idx),
        .rd_state   (rd_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step_start = 1'b0;
        spk_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic read_state(input int i, output logic [7:0] v);
        rd_idx = 2'(i);
        #1;
        v = rd_state;
    endtask

    // Runs one timestep; cycle numbers are relative to the accept cycle (0).
    task automatic do_step(input logic [31:0] cur_v, input logic [7:0] thr,
                           input logic [2:0] ls, input int stall);
        int cyc;
        int st;
        logic [1:0] first_idx;
        ev_q.delete();
        unstable = 0;
        done_cyc = -1;
        st = 0;
        first_idx = '0;
        currents = cur_v;
        threshold = thr;
        leak_shift = ls;
        step_start = 1'b1;
        spk_ready = 1'b1;
        tick;
        step_start = 1'b0;
        currents = '1;
        threshold = '0;
        leak_shift = '0;
        cyc = 1;
        busy_c1 = step_busy;
        while (cyc < 200 && done_cyc < 0) begin
            if (spk_valid) begin
                if (st == 0) first_idx = spk_idx;
                else if (spk_idx !== first_idx) unstable++;
                if (st < stall) begin
                    spk_ready = 1'b0;
                    st++;
                end else begin
                    spk_ready = 1'b1;
                    ev_q.push_back(int'(spk_idx));
                    st = 0;
                end
            end
            if (step_done) done_cyc = cyc;
            else begin
                tick;
                cyc++;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL step_timeout: no step_done within %0d cycles", cyc);
        end
        spk_ready = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        do_reset;
        checks++;
        if ({step_busy, step_done, spk_valid, spk_idx} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b valid=%b idx=%0d expected all 0",
                     step_busy, step_done, spk_valid, spk_idx);
        end
        for (int i = 0; i < 4; i++) begin
            read_state(i, v);
            checks++;
            if (v !== 8'd0) begin
                failures++;
                $display("FAIL reset_state%0d: got %0d expected 0", i, v);
            end
        end
    endtask

    task automatic test_baseline;
        logic [7:0] v;
        do_reset;
        do_step(32'h0, 8'd127, 3'd1, 0);
        checks++;
        if (busy_c1 !== 1'b1) begin
            failures++;
            $display("FAIL baseline_busy: got %b expected 1", busy_c1);
        end
        checks++;
        if (done_cyc != 5) begin
            failures++;
            $display("FAIL baseline_done_cycle: got %0d expected 5", done_cyc);
        end
        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL baseline_spikes: got %0d expected 0", ev_q.size());
        end
        checks++;
        if (step_busy !== 1'b0) begin
            failures++;
            $display("FAIL baseline_busy_after: got %b expected 0", step_busy);
        end
        read_state(3, v);
        checks++;
        if (v !== 8'd0) begin
            failures++;
            $display("FAIL baseline_state3: got %0d expected 0", v);
        end
    endtask

    task automatic test_integrate_fire;
        logic [7:0] v;
        do_reset;
        do_step(32'h0000_0064, 8'd127, 3'd1, 0);
        read_state(0, v);
        checks++;
        if (v !== 8'd100) begin
            failures++;
            $display("FAIL integ_state0: got %0d expected 100", v);
        end
        do_step(32'h0000_0064, 8'd127, 3'd1, 0);
        checks++;
        if (ev_q.size() != 1 || ev_q[0] != 0) begin
            failures++;
            $display("FAIL fire_event: got count=%0d expected one spike idx 0", ev_q.size());
        end
        checks++;
        if (done_cyc != 6) begin
            failures++;
            $display("FAIL fire_done_cycle: got %0d expected 6", done_cyc);
        end
        read_state(0, v);
        checks++;
        if (v !== 8'd0) begin
            failures++;
            $display("FAIL fire_state0: got %0d expected 0", v);
        end
    endtask

    task automatic test_leak;
        logic [7:0] v;
        do_reset;
        do_step(32'h2800_0000, 8'd200, 3'd2, 0);
        do_step(32'h2800_0000, 8'd200, 3'd2, 0);
        read_state(3, v);
        checks++;
        if (v !== 8'd50) begin
            failures++;
            $display("FAIL leak_step2: got %0d expected 50", v);
        end
        do_step(32'h2800_0000, 8'd200, 3'd2, 0);
        read_state(3, v);
        checks++;
        if (v !== 8'd52) begin
            failures++;
            $display("FAIL leak_step3: got %0d expected 52", v);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] v;
        do_reset;
        do_step(32'h00C8_0000, 8'd255, 3'd1, 0);
        read_state(2, v);
        checks++;
        if (v !== 8'd200) begin
            failures++;
            $display("FAIL sat_preload: got %0d expected 200", v);
        end
        do_step(32'h00FF_0000, 8'd255, 3'd1, 0);
        checks++;
        if (ev_q.size() != 1 || ev_q[0] != 2) begin
            failures++;
            $display("FAIL sat_spike: got count=%0d expected one spike idx 2", ev_q.size());
        end
        read_state(2, v);
        checks++;
        if (v !== 8'd0) begin
            failures++;
            $display("FAIL sat_state2: got %0d expected 0", v);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        do_step(32'h0000_C800, 8'd127, 3'd1, 0);
        checks++;
        if (done_cyc != 6 || ev_q.size() != 1) begin
            failures++;
            $display("FAIL bp_nostall: done=%0d spikes=%0d expected done=6 spikes=1",
                     done_cyc, ev_q.size());
        end
        do_step(32'h0000_C800, 8'd127, 3'd1, 3);
        checks++;
        if (done_cyc != 9) begin
            failures++;
            $display("FAIL bp_done_cycle: got %0d expected 9", done_cyc);
        end
        checks++;
        if (ev_q.size() != 1 || ev_q[0] != 1 || unstable != 0) begin
            failures++;
            $display("FAIL bp_event: count=%0d unstable=%0d expected one stable spike idx 1",
                     ev_q.size(), unstable);
        end
    endtask

    task automatic test_threshold_zero;
        do_reset;
        do_step(32'h0, 8'd0, 3'd0, 0);
        checks++;
        if (ev_q.size() != 4 || ev_q[0] != 0 || ev_q[1] != 1 || ev_q[2] != 2 || ev_q[3] != 3) begin
            failures++;
            $display("FAIL thr0_events: got count=%0d expected spikes 0,1,2,3", ev_q.size());
        end
        checks++;
        if (done_cyc != 9) begin
            failures++;
            $display("FAIL thr0_done_cycle: got %0d expected 9", done_cyc);
        end
    endtask

    task automatic test_back_to_back;
        logic b7;
        logic d5;
        do_reset;
        currents = '0;
        threshold = 8'd127;
        leak_shift = 3'd1;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        tick;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        tick;
        tick;
        d5 = step_done;
        step_start = 1'b1;
        tick;
        step_start = 1'b0;
        tick;
        b7 = step_busy;
        checks++;
        if (d5 !== 1'b1 || b7 !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start: done@5=%b busy@7=%b expected 1 and 0", d5, b7);
        end
        do_step(32'h0, 8'd127, 3'd1, 0);
        do_step(32'h0, 8'd127, 3'd1, 0);
        checks++;
        if (done_cyc != 5 || busy_c1 !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back: done=%0d busy=%b expected 5 and 1", done_cyc, busy_c1);
        end
    endtask

    task automatic test_reset_mid_sweep;
        logic [7:0] v;
        int seen;
        do_reset;
        do_step(32'h0A0A_0A0A, 8'd255, 3'd0, 0);
        read_state(0, v);
        checks++;
        if (v !== 8'd10) begin
            failures++;
            $display("FAIL mid_preload: got %0d expected 10", v);
        end
        currents = 32'h0A0A_0A0A;
        threshold = 8'd255;
        step_start = 1'b1;
        tick;
        tick;
        step_start = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({step_busy, step_done, spk_valid} !== 3'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b valid=%b expected 0",
                     step_busy, step_done, spk_valid);
        end
        for (int i = 0; i < 4; i++) begin
            read_state(i, v);
            checks++;
            if (v !== 8'd0) begin
                failures++;
                $display("FAIL mid_reset_state%0d: got %0d expected 0", i, v);
            end
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (step_done || step_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_refractory;
        int exp_n[4];
`ifdef LIF_REFRACTORY_EN
        exp_n = '{1, 0, 0, 1};
`else
        exp_n = '{1, 1, 1, 1};
`endif
        do_reset;
        for (int s = 0; s < 4; s++) begin
            do_step(32'h0000_00C8, 8'd127, 3'd1, 0);
            checks++;
            if (ev_q.size() != exp_n[s]) begin
                failures++;
                $display("FAIL refrac_step%0d: got %0d spikes expected %0d",
                         s + 1, ev_q.size(), exp_n[s]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_baseline;
        test_integrate_fire;
        test_leak;
        test_saturation;
        test_backpressure;
        test_threshold_zero;
        test_back_to_back;
        test_reset_mid_sweep;
        test_refractory;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
